pll_reset_sequencer: RTL

Reset and lock supervisor for the 50 MHz board reference-clock domain, wrapped around the system PLL. It drives the PLL's active-high reset, synchronises and debounces the PLL lock indicator, and releases a clean system reset only after lock has been stable for a programmable time. On loss of lock it re-resets the PLL automatically, and it counts lock losses and lock timeouts for debug.

---
 rtl/pll_reset_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: pulses the PLL reset, filters the lock indicator and releases
// the system reset once lock has been stable; counts lock losses and lock timeouts.
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [1:0] state_o,
   output logic [7:0] lock_loss_cnt,
   output logic [7:0] timeout_cnt
);

   typedef enum logic [1:0] {
      StPllReset = 2'd0,
      StWaitLock = 2'd1,
      StStable   = 2'd2,
      StRun      = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_q, lk_q;
   logic             pll_rst_q, sys_rst_n_q;
   logic [7:0]       loss_q, loss_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             loss_inc, tmo_inc;

   // relock_req outranks every other transition except inside PLL_RESET, where it is ignored
   always_comb begin
      state_d  = state_q;
      loss_inc = 1'b0;
      tmo_inc  = 1'b0;
      unique case (state_q)
         StPllReset: begin
            if (cnt_q == RstLast) state_d = StWaitLock;
         end
         StWaitLock: begin
            if (relock_req) begin
               state_d = StPllReset;
            end else if (lk_q) begin
               state_d = StStable;
            end else if (cnt_q == TimeoutLast) begin
               tmo_inc = 1'b1;
               state_d = StPllReset;
            end
         end
         StStable: begin
            if (relock_req) begin
               state_d = StPllReset;
            end else if (!lk_q) begin
               state_d = StWaitLock;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (relock_req) begin
               state_d = StPllReset;
            end else if (!lk_q) begin
               loss_inc = 1'b1;
               state_d  = StPllReset;
            end
         end
         default: state_d = StPllReset;
      endcase

      cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      loss_d = (loss_inc && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
      tmo_d  = (tmo_inc && tmo_q != 8'hFF) ? tmo_q + 8'd1 : tmo_q;
   end

   // Outputs are decoded from state_d so they move on the same edge as the state
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 1'b0;
         lk_q        <= 1'b0;
         state_q     <= StPllReset;
         cnt_q       <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         loss_q      <= 8'd0;
         tmo_q       <= 8'd0;
      end else begin
         sync_q      <= pll_locked;
         lk_q        <= sync_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_rst_q   <= (state_d == StPllReset);
         sys_rst_n_q <= (state_d == StRun);
         loss_q      <= loss_d;
         tmo_q       <= tmo_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst_n     = sys_rst_n_q;
   assign ready         = sys_rst_n_q;
   assign state_o       = state_q;
   assign lock_loss_cnt = loss_q;
   assign timeout_cnt   = tmo_q;

endmodule
